// File: rtl/eth_pkg.sv
// Shared frame-type codes, ARP opcodes and scheduler state encoding for the Ethernet TX path.
package eth_pkg;

  localparam logic [3:0] PKT_NONE     = 4'd0;
  localparam logic [3:0] PKT_ARP_REQ  = 4'd1;
  localparam logic [3:0] PKT_ARP_RESP = 4'd2;
  localparam logic [3:0] PKT_UDP      = 4'd3;

  localparam logic [1:0] ARP_OP_NONE = 2'd0;
  localparam logic [1:0] ARP_OP_REQ  = 2'd1;
  localparam logic [1:0] ARP_OP_RESP = 2'd2;

  localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    StIdle,
    StArb,
    StLaunch,
    StBusy
  } tx_state_e;

endpackage

// File: rtl/eth_ms_timer.sv
// Millisecond tick divider plus a period counter over ticks; restart clears the period count.
module eth_ms_timer #(
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned PERIOD   = 3000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick,
  output logic wrap
);

  localparam int unsigned DivW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PerW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);
  localparam logic [PerW-1:0] PerLast = PerW'(PERIOD - 1);

  logic [DivW-1:0] div_q, div_d;
  logic [PerW-1:0] per_q, per_d;

  assign tick = (div_q == DivLast);
  assign wrap = tick && (per_q == PerLast);

  always_comb begin
    div_d = tick ? '0 : div_q + DivW'(1);
    per_d = per_q;
    if (restart) begin
      per_d = '0;
    end else if (tick) begin
      per_d = wrap ? '0 : per_q + PerW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;
      per_q <= '0;
    end else begin
      div_q <= div_d;
      per_q <= per_d;
    end
  end

endmodule

// File: rtl/eth_tx_sched.sv
// Transmit scheduler: arbitrates ARP response / ARP request / UDP per slot, owns the ARP cache
// entry for TARGET_IP and hands the chosen frame to the sender with a start strobe.
module eth_tx_sched
  import eth_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 100000,
  parameter int unsigned ARP_PERIOD_MS = 3000,
  parameter int unsigned SOP_TMO       = 4095,
  parameter logic [31:0] TARGET_IP     = 32'h0A00006F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  i_arp_op,
  input  logic [47:0] i_arp_mac,
  input  logic [31:0] i_arp_ip,
  input  logic        i_udp_req,
  input  logic        i_tx_sop,
  input  logic        i_tx_eop,
  output logic [3:0]  o_pkt_type,
  output logic [47:0] o_target_mac,
  output logic [31:0] o_target_ip,
  output logic        o_start,
  output logic        o_mac_valid,
  output logic        o_busy
);

  localparam logic [11:0] WdLast = 12'(SOP_TMO - 1);

  tx_state_e   state_q, state_d;
  logic [3:0]  pkt_type_q, pkt_type_d;
  logic [47:0] target_mac_q, target_mac_d;
  logic [31:0] target_ip_q, target_ip_d;
  logic        start_q, start_d;
  logic [11:0] wd_q, wd_d;
  logic        req_pending_q, req_pending_d;
  logic        resp_pending_q, resp_pending_d;
  logic [47:0] resp_mac_q, resp_mac_d;
  logic [31:0] resp_ip_q, resp_ip_d;
  logic [47:0] cache_mac_q, cache_mac_d;
  logic        mac_valid_q, mac_valid_d;
  logic        waiting_q, waiting_d;

  logic timer_tick, timer_wrap;
  logic resp_hit, req_in, sop_ok, req_sop, resp_sop;

  assign resp_hit = (i_arp_op == ARP_OP_RESP) && (i_arp_ip == TARGET_IP);
  assign req_in   = (i_arp_op == ARP_OP_REQ);
  // sop only means something while a launched frame waits for it
  assign sop_ok   = (state_q == StLaunch) && i_tx_sop;
  assign req_sop  = sop_ok && (pkt_type_q == PKT_ARP_REQ);
  assign resp_sop = sop_ok && (pkt_type_q == PKT_ARP_RESP);

  eth_ms_timer #(
    .TICK_DIV (TICK_DIV),
    .PERIOD   (ARP_PERIOD_MS)
  ) u_ms_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (req_sop),
    .tick    (timer_tick),
    .wrap    (timer_wrap)
  );

  // Cache, timeout and pending-flag bookkeeping; later assignments take priority.
  always_comb begin
    req_pending_d = req_pending_q;
    if (req_sop)    req_pending_d = 1'b0;
    if (timer_wrap) req_pending_d = 1'b1;

    resp_pending_d = resp_pending_q;
    resp_mac_d     = resp_mac_q;
    resp_ip_d      = resp_ip_q;
    if (resp_sop) resp_pending_d = 1'b0;
    if (req_in) begin
      resp_pending_d = 1'b1;
      resp_mac_d     = i_arp_mac;
      resp_ip_d      = i_arp_ip;
    end

    waiting_d = waiting_q;
    if (resp_hit) waiting_d = 1'b0;
    if (req_sop)  waiting_d = 1'b1;

    mac_valid_d = mac_valid_q;
    cache_mac_d = cache_mac_q;
    if (timer_wrap && waiting_q) mac_valid_d = 1'b0;
    if (resp_hit) begin
      mac_valid_d = 1'b1;
      cache_mac_d = i_arp_mac;
    end
  end

  always_comb begin
    state_d      = state_q;
    pkt_type_d   = pkt_type_q;
    target_mac_d = target_mac_q;
    target_ip_d  = target_ip_q;
    start_d      = 1'b0;
    wd_d         = wd_q;
    unique case (state_q)
      StIdle: state_d = StArb;
      StArb: begin
        wd_d       = '0;
        pkt_type_d = PKT_NONE;
        if (resp_pending_q) begin
          pkt_type_d   = PKT_ARP_RESP;
          target_mac_d = resp_mac_q;
          target_ip_d  = resp_ip_q;
        end else if (req_pending_q) begin
          pkt_type_d   = PKT_ARP_REQ;
          target_mac_d = mac_valid_q ? cache_mac_q : MAC_BCAST;
          target_ip_d  = TARGET_IP;
        end else if (i_udp_req && mac_valid_q) begin
          pkt_type_d   = PKT_UDP;
          target_mac_d = cache_mac_q;
          target_ip_d  = TARGET_IP;
        end
        if (pkt_type_d != PKT_NONE) begin
          state_d = StLaunch;
          start_d = 1'b1;
        end
      end
      StLaunch: begin
        if (i_tx_sop) begin
          state_d = i_tx_eop ? StIdle : StBusy;
          if (i_tx_eop) pkt_type_d = PKT_NONE;
        end else if (wd_q == WdLast) begin
          // sender never picked it up: drop back and let arbitration retry
          state_d    = StIdle;
          pkt_type_d = PKT_NONE;
        end else begin
          wd_d = wd_q + 12'd1;
        end
      end
      StBusy: begin
        if (i_tx_eop) begin
          state_d    = StIdle;
          pkt_type_d = PKT_NONE;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      pkt_type_q     <= PKT_NONE;
      target_mac_q   <= MAC_BCAST;
      target_ip_q    <= '0;
      start_q        <= 1'b0;
      wd_q           <= '0;
      req_pending_q  <= 1'b1;
      resp_pending_q <= 1'b0;
      resp_mac_q     <= '0;
      resp_ip_q      <= '0;
      cache_mac_q    <= '0;
      mac_valid_q    <= 1'b0;
      waiting_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      pkt_type_q     <= pkt_type_d;
      target_mac_q   <= target_mac_d;
      target_ip_q    <= target_ip_d;
      start_q        <= start_d;
      wd_q           <= wd_d;
      req_pending_q  <= req_pending_d;
      resp_pending_q <= resp_pending_d;
      resp_mac_q     <= resp_mac_d;
      resp_ip_q      <= resp_ip_d;
      cache_mac_q    <= cache_mac_d;
      mac_valid_q    <= mac_valid_d;
      waiting_q      <= waiting_d;
    end
  end

  assign o_pkt_type   = pkt_type_q;
  assign o_target_mac = target_mac_q;
  assign o_target_ip  = target_ip_q;
  assign o_start      = start_q;
  assign o_mac_valid  = mac_valid_q;
  assign o_busy       = (state_q == StLaunch) || (state_q == StBusy);

endmodule

// File: tb/tb_eth_tx_sched.sv
// Self-checking bench for eth_tx_sched: expected frames are queued as stimulus is applied and
// compared when the scheduler raises o_start.
module tb_eth_tx_sched;

  localparam int unsigned SopTmo = 20;
  localparam logic [31:0] Tgt    = 32'h0A00006F;
  localparam logic [47:0] Bcast  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] MacA   = 48'h0011_2233_4455;
  localparam logic [47:0] MacB   = 48'hAABB_CCDD_EE01;
  localparam logic [47:0] MacC   = 48'hAABB_CCDD_EE02;
  localparam logic [47:0] MacD   = 48'hAABB_CCDD_EE03;
  localparam logic [31:0] IpB    = 32'h0A000005;
  localparam logic [31:0] IpC    = 32'h0A000006;
  localparam logic [31:0] IpD    = 32'h0A000007;

  typedef struct packed {
    logic [3:0]  t;
    logic [47:0] m;
    logic [31:0] ip;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  i_arp_op = '0;
  logic [47:0] i_arp_mac = '0;
  logic [31:0] i_arp_ip = '0;
  logic        i_udp_req = 1'b0;
  logic        i_tx_sop = 1'b0;
  logic        i_tx_eop = 1'b0;
  logic [3:0]  o_pkt_type;
  logic [47:0] o_target_mac;
  logic [31:0] o_target_ip;
  logic        o_start;
  logic        o_mac_valid;
  logic        o_busy;

  frame_t exp_q[$];
  int     n_chk = 0;
  int     n_fail = 0;

  eth_tx_sched #(
    .TICK_DIV      (10),
    .ARP_PERIOD_MS (5),
    .SOP_TMO       (SopTmo),
    .TARGET_IP     (Tgt)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_arp_op     (i_arp_op),
    .i_arp_mac    (i_arp_mac),
    .i_arp_ip     (i_arp_ip),
    .i_udp_req    (i_udp_req),
    .i_tx_sop     (i_tx_sop),
    .i_tx_eop     (i_tx_eop),
    .o_pkt_type   (o_pkt_type),
    .o_target_mac (o_target_mac),
    .o_target_ip  (o_target_ip),
    .o_start      (o_start),
    .o_mac_valid  (o_mac_valid),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    i_arp_op  = '0;
    i_udp_req = 1'b0;
    i_tx_sop  = 1'b0;
    i_tx_eop  = 1'b0;
    exp_q.delete();
    repeat (3) step();
  endtask

  // Edges until o_start is seen, bounded by max.
  task automatic await_start(input int max, output bit ok, output int cyc, output frame_t got);
    ok  = 1'b0;
    cyc = 0;
    got = '0;
    while (cyc < max) begin
      step();
      cyc++;
      if (o_start) begin
        ok  = 1'b1;
        got = {o_pkt_type, o_target_mac, o_target_ip};
        break;
      end
    end
  endtask

  task automatic pulse_arp(input logic [1:0] op, input logic [47:0] mac, input logic [31:0] ip);
    i_arp_op  = op;
    i_arp_mac = mac;
    i_arp_ip  = ip;
    step();
    i_arp_op  = '0;
  endtask

  task automatic send_frame(input int len);
    i_tx_sop = 1'b1;
    i_tx_eop = (len == 1);
    step();
    i_tx_sop = 1'b0;
    i_tx_eop = 1'b0;
    if (len > 1) begin
      repeat (len - 2) step();
      i_tx_eop = 1'b1;
      step();
      i_tx_eop = 1'b0;
    end
  endtask

  // Reset, release and serve the initial ARP request.
  task automatic boot();
    bit ok; int cyc; frame_t got;
    do_reset();
    rst_n = 1'b1;
    await_start(10, ok, cyc, got);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL boot_start: o_start not seen, required within 10 cycles");
    end else begin
      send_frame(2);
    end
  endtask

  task automatic test_reset();
    bit ok; int cyc; frame_t got, exp;
    do_reset();
    n_chk++;
    if ({o_pkt_type, o_target_mac, o_target_ip, o_start, o_mac_valid, o_busy}
        !== {4'd0, Bcast, 32'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_values: got type=%0d mac=%h ip=%h start=%b valid=%b busy=%b, required 0 %h 0 0 0 0",
               o_pkt_type, o_target_mac, o_target_ip, o_start, o_mac_valid, o_busy, Bcast);
    end
    rst_n = 1'b1;
    exp_q.push_back('{4'd1, Bcast, Tgt});
    await_start(10, ok, cyc, got);
    exp = exp_q.pop_front();
    n_chk++;
    if (!ok || got !== exp) begin
      n_fail++;
      $display("FAIL reset_first_req: got %h (seen=%b), required %h", got, ok, exp);
    end
    n_chk++;
    if (cyc !== 2) begin
      n_fail++;
      $display("FAIL reset_latency: got %0d cycles, required 2", cyc);
    end
    n_chk++;
    if (o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL launch_busy: got %b, required 1", o_busy);
    end
    send_frame(2);
    n_chk++;
    if (o_pkt_type !== 4'd0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL after_eop: got type=%0d busy=%b, required 0 0", o_pkt_type, o_busy);
    end
  endtask

  task automatic test_cache_udp();
    bit ok; int cyc; frame_t got, exp;
    boot();
    pulse_arp(2'd2, MacA, Tgt);
    n_chk++;
    if (o_mac_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL cache_valid: got %b, required 1", o_mac_valid);
    end
    i_udp_req = 1'b1;
    exp_q.push_back('{4'd3, MacA, Tgt});
    await_start(10, ok, cyc, got);
    i_udp_req = 1'b0;
    exp = exp_q.pop_front();
    n_chk++;
    if (!ok || got !== exp) begin
      n_fail++;
      $display("FAIL udp_frame: got %h (seen=%b), required %h", got, ok, exp);
    end
    send_frame(2);
    n_chk++;
    if (o_pkt_type !== 4'd0) begin
      n_fail++;
      $display("FAIL udp_done: got type %0d, required 0", o_pkt_type);
    end
  endtask

  task automatic test_foreign_resp();
    int starts;
    boot();
    pulse_arp(2'd2, MacB, 32'h0A000063);
    n_chk++;
    if (o_mac_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL foreign_valid: got %b, required 0", o_mac_valid);
    end
    i_udp_req = 1'b1;
    starts = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (o_start) starts++;
    end
    i_udp_req = 1'b0;
    n_chk++;
    if (starts !== 0) begin
      n_fail++;
      $display("FAIL foreign_no_udp: got %0d starts, required 0", starts);
    end
  endtask

  task automatic test_back_to_back();
    bit ok; int cyc; frame_t got, exp;
    boot();
    pulse_arp(2'd2, MacA, Tgt);
    i_udp_req = 1'b1;
    exp_q.push_back('{4'd3, MacA, Tgt});
    await_start(10, ok, cyc, got);
    i_udp_req = 1'b0;
    exp = exp_q.pop_front();
    n_chk++;
    if (!ok || got !== exp) begin
      n_fail++;
      $display("FAIL b2b_udp: got %h (seen=%b), required %h", got, ok, exp);
    end
    i_tx_sop = 1'b1;
    step();
    i_tx_sop = 1'b0;
    pulse_arp(2'd1, MacB, IpB);
    pulse_arp(2'd1, MacC, IpC);
    exp_q.push_back('{4'd2, MacC, IpC});
    n_chk++;
    if (o_pkt_type !== 4'd3 || o_target_mac !== MacA) begin
      n_fail++;
      $display("FAIL b2b_stable: got type=%0d mac=%h, required 3 %h", o_pkt_type, o_target_mac, MacA);
    end
    i_tx_eop = 1'b1;
    step();
    i_tx_eop = 1'b0;
    await_start(10, ok, cyc, got);
    exp = exp_q.pop_front();
    n_chk++;
    if (!ok || got !== exp) begin
      n_fail++;
      $display("FAIL b2b_resp: got %h (seen=%b), required %h", got, ok, exp);
    end
    n_chk++;
    if (cyc !== 2) begin
      n_fail++;
      $display("FAIL b2b_latency: got %0d cycles, required 2", cyc);
    end
    // A request landing on the response's sop cycle must survive the clear.
    i_tx_sop  = 1'b1;
    i_arp_op  = 2'd1;
    i_arp_mac = MacD;
    i_arp_ip  = IpD;
    step();
    i_tx_sop  = 1'b0;
    i_arp_op  = '0;
    exp_q.push_back('{4'd2, MacD, IpD});
    i_tx_eop = 1'b1;
    step();
    i_tx_eop = 1'b0;
    await_start(10, ok, cyc, got);
    exp = exp_q.pop_front();
    n_chk++;
    if (!ok || got !== exp) begin
      n_fail++;
      $display("FAIL b2b_resp_on_sop: got %h (seen=%b), required %h", got, ok, exp);
    end
    send_frame(2);
    n_chk++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: got busy %b, required 0", o_busy);
    end
  endtask

  task automatic test_arp_timeout();
    bit ok; int cyc; frame_t got, exp;
    boot();
    pulse_arp(2'd2, MacA, Tgt);
    n_chk++;
    if (o_mac_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_valid: got %b, required 1", o_mac_valid);
    end
    exp_q.push_back('{4'd1, MacA, Tgt});
    await_start(80, ok, cyc, got);
    exp = exp_q.pop_front();
    n_chk++;
    if (!ok || got !== exp) begin
      n_fail++;
      $display("FAIL tmo_refresh: got %h (seen=%b), required %h", got, ok, exp);
    end
    send_frame(2);
    cyc = 0;
    while (o_mac_valid && cyc < 80) begin
      step();
      cyc++;
    end
    n_chk++;
    if (o_mac_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_fall: got valid %b after %0d cycles, required 0", o_mac_valid, cyc);
    end
    exp_q.push_back('{4'd1, Bcast, Tgt});
    await_start(5, ok, cyc, got);
    exp = exp_q.pop_front();
    n_chk++;
    if (cyc !== 1) begin
      n_fail++;
      $display("FAIL tmo_req_latency: got %0d cycles, required 1", cyc);
    end
    n_chk++;
    if (!ok || got !== exp) begin
      n_fail++;
      $display("FAIL tmo_bcast: got %h (seen=%b), required %h", got, ok, exp);
    end
    send_frame(2);
  endtask

  task automatic test_sop_timeout();
    bit ok; int cyc; frame_t got, exp;
    do_reset();
    rst_n = 1'b1;
    exp_q.push_back('{4'd1, Bcast, Tgt});
    await_start(10, ok, cyc, got);
    exp = exp_q.pop_front();
    n_chk++;
    if (!ok || got !== exp) begin
      n_fail++;
      $display("FAIL sop_first: got %h (seen=%b), required %h", got, ok, exp);
    end
    cyc = 0;
    while (o_busy && cyc < 40) begin
      step();
      cyc++;
    end
    n_chk++;
    if (cyc !== SopTmo) begin
      n_fail++;
      $display("FAIL sop_tmo_len: got %0d cycles, required %0d", cyc, SopTmo);
    end
    n_chk++;
    if (o_pkt_type !== 4'd0) begin
      n_fail++;
      $display("FAIL sop_tmo_type: got %0d, required 0", o_pkt_type);
    end
    exp_q.push_back('{4'd1, Bcast, Tgt});
    await_start(10, ok, cyc, got);
    exp = exp_q.pop_front();
    n_chk++;
    if (cyc !== 2) begin
      n_fail++;
      $display("FAIL sop_retry_latency: got %0d cycles, required 2", cyc);
    end
    n_chk++;
    if (!ok || got !== exp) begin
      n_fail++;
      $display("FAIL sop_retry: got %h (seen=%b), required %h", got, ok, exp);
    end
    i_tx_sop = 1'b1;
    step();
    i_tx_sop = 1'b0;
    n_chk++;
    if (o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_before_rst: got %b, required 1", o_busy);
    end
    rst_n = 1'b0;
    step();
    n_chk++;
    if ({o_pkt_type, o_target_mac, o_target_ip, o_start, o_mac_valid, o_busy}
        !== {4'd0, Bcast, 32'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL midframe_reset: got type=%0d mac=%h ip=%h start=%b valid=%b busy=%b, required 0 %h 0 0 0 0",
               o_pkt_type, o_target_mac, o_target_ip, o_start, o_mac_valid, o_busy, Bcast);
    end
  endtask

  initial begin
    test_reset();
    test_cache_udp();
    test_foreign_resp();
    test_back_to_back();
    test_arp_timeout();
    test_sop_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000 ns, required to finish earlier");
    $fatal(1, "timeout");
  end

endmodule
